// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and default sizing.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: first set request at or after (last+1) mod N, wrapping.
// Purely combinational; no latency, no backpressure.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_next,
    output logic          o_any
);

    int          w_pos;
    logic [IW-1:0] w_sel;

    // Walk farthest-to-nearest so the nearest candidate after i_last wins.
    always_comb begin
        o_next = '0;
        w_pos  = 0;
        w_sel  = '0;
        for (int k = N; k >= 1; k--) begin
            w_pos = (int'(i_last) + k) % N;
            w_sel = IW'(w_pos);
            if (i_req[w_sel]) begin
                o_next = w_sel;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding a FIFO: grants one requester per packet/burst.
// One cycle arbitration latency; wfull deasserts req_ready/winc and holds the grant.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   r_last_grant;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   w_beat_inc;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic            w_xfer;
    logic            w_done;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .o_next (w_pick),
        .o_any  (w_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_beat_inc = r_beat + BW'(1);
    assign wdata      = w_words[r_grant_id];
    assign grant_id   = r_grant_id;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        winc        = 1'b0;
        busy        = 1'b0;
        w_xfer      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy                  = 1'b1;
                req_ready[r_grant_id] = ~wfull;
                w_xfer                = req_valid[r_grant_id] & ~wfull;
                winc                  = w_xfer;
                // Release on end-of-packet or when this beat fills the burst quota.
                w_done = w_xfer & (req_last[r_grant_id] | (w_beat_inc == BW'(MAX_BURST)));
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_grant_id   <= '0;
            r_beat       <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
        end else if (r_state == IDLE) begin
            if (w_any) begin
                r_grant_id <= w_pick;
                r_beat     <= '0;
            end
        end else if (w_xfer) begin
            r_beat <= w_beat_inc;
            if (w_done) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

endmodule
